// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a valid/ack output register,
// a one-cycle framing-error pulse and a sticky overrun flag.
module uart_rx #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] HALF_LAST = 16'(CLK_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4,
        S_BREAK = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_sync_q;
    logic        rx_s;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;

    assign rx_s = rx_sync_q;

    // Next-state and next-output computation for the receive FSM and handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = overrun_q;

        if (rx_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (!rx_s) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 16'd0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = S_DONE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_DONE: begin
                // A completing byte beats a simultaneous ack: it stays valid.
                cnt_d        = 16'd0;
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
                if (data_valid_q && !rx_ack) begin
                    overrun_d = 1'b1;
                end else if (rx_ack) begin
                    overrun_d = 1'b0;
                end else begin
                    overrun_d = overrun_q;
                end
                state_d = S_IDLE;
            end
            S_BREAK: begin
                cnt_d = 16'd0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                cnt_d   = 16'd0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Synchronizer and all state registers; the line synchronizer resets to idle-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
